if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//   Fetch stage between the instruction memory port and the IF/ID register.
//   Issues sequential fetch requests, keeps up to DEPTH instructions in flight
//   or buffered, and hands them to IF/ID in order with a valid/ready handshake.
//   An EX-stage redirect on a mispredict flushes the queue and restarts fetch
//   at the corrected PC.
// PARAMETERS
//   DEPTH     4             slots (in flight + buffered); power of 2, >=2
//   RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//   clk              in   1   clock, rising edge
//   rst              in   1   asynchronous reset, active-high
//   imem_req_valid   out  1   fetch request valid
//   imem_req_addr    out  32  fetch address (word aligned)
//   imem_req_ready   in   1   memory accepts the request this cycle
//   imem_resp_valid  in   1   instruction returned (in order, >=1 cycle after accept)
//   imem_resp_data   in   32  returned instruction word
//   redirect_en      in   1   flush and restart (EX correctpc path)
//   redirect_pc      in   32  restart address
//   ifid_valid       out  1   head instruction available
//   ifid_instr       out  32  head instruction; 32'h0000_0013 (NOP) when !ifid_valid
//   ifid_instr_addr  out  32  PC of the head instruction
//   ifid_ready       in   1   IF/ID consumes the head; 0 = pipeline stall
// BEHAVIOUR
//   - Slot ring with three pointers: alloc (request accepted), fill (response
//     written), head (consumed). Each slot holds addr, instr and a filled flag.
//     Pointers are log2(DEPTH)+1 bits; full = alloc-head == DEPTH.
//   - FSM: BOOT -> RUN (always after 1 cycle); RUN -> FLUSH on redirect_en while
//     outstanding (alloc-fill) > 0; FLUSH -> RUN when drop_cnt reaches 0.
//   - BOOT: no requests, ifid_valid=0. This is the reset state.
//   - RUN: imem_req_valid = !full. On valid&ready: slot[alloc].addr=fetch_pc,
//     alloc++, fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
//   - Response in RUN: slot[fill].instr=data, filled=1, fill++.
//   - Head: ifid_valid = slot[head].filled. A transfer is ifid_valid&ifid_ready:
//     head++, the slot is freed. The freed slot counts as free for the same
//     cycle's request (enqueue and dequeue may both happen in one cycle).
//   - redirect_en (any state): all slots cleared, pointers equalised,
//     fetch_pc=redirect_pc, ifid_valid=0 next cycle.
//     drop_cnt = in-flight count, excluding any response arriving in the same
//     cycle. That response is discarded.
//     A request accepted in the redirect cycle also counts in drop_cnt.
//     Redirect has priority over every other event.
//   - FLUSH: imem_req_valid=0; every response decrements drop_cnt and is
//     discarded. A further redirect in FLUSH reloads fetch_pc and keeps drop_cnt
//     (plus any request accepted in that cycle).
//   - imem_req_addr = fetch_pc whenever imem_req_valid is 0 or 1. It is held
//     stable while valid&!ready.
//   - Response with no outstanding request: ignored (assertion in sim).
//   - Reset mid-operation: all state cleared immediately and the FSM enters BOOT.
//     Outputs after reset: imem_req_valid=0, imem_req_addr=RESET_PC,
//     ifid_valid=0, ifid_instr=32'h0000_0013, ifid_instr_addr=0.
//   - Latency: accept at cycle t, response at t+k -> ifid_valid at t+k+1.
// CONFIGURATION
//   IF_PREFETCH_BYPASS_EN defined: when the head slot is the fill slot and a
//     response arrives in RUN, the response drives ifid_instr/ifid_valid
//     combinationally the same cycle. It is also written if not consumed.
//     Latency becomes t+k.
//   Undefined: responses are always registered first. There is no
//     imem_resp -> ifid combinational path.
// TESTING
//   1 Reset release, ready=1, 1-cycle memory: addrs 0,4,8.. issued; ifid PCs
//     0,4,8 in order, first ifid_valid 3 cycles after reset release.
//   2 ifid_ready=0 for 10 cycles: exactly DEPTH=4 requests accepted, then
//     req_valid=0. Release -> PCs continue without gap or duplicate.
//   3 redirect_en with redirect_pc=0x100 while 2 responses are in flight: both
//     are dropped, FSM in FLUSH for 2 responses, next ifid PC=0x100.
//   4 imem_req_ready=0 for 5 cycles: req_addr and req_valid held stable,
//     no slot allocated.
//   5 redirect_en in the same cycle as a response and an ifid transfer:
//     response discarded, next valid PC = redirect_pc.
//   6 fetch_pc=0xFFFF_FFF8: addrs FFF8, FFFC, 0000 issued and delivered in order.
//     With IF_PREFETCH_BYPASS_EN: response seen on ifid the same cycle.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Fetch prefetch queue: issues sequential imem requests, buffers up to DEPTH
// instructions (in flight + filled) and hands them to IF/ID in order.
// Latency: accept at t, response at t+k -> ifid_valid at t+k+1 (t+k with bypass).
// Backpressure: ifid_ready=0 holds the head; imem_req_valid drops when all slots are used.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   imem_req_valid/_addr/_ready       fetch request handshake (addr held while stalled)
//   imem_resp_valid/_data             in-order instruction return
//   redirect_en/redirect_pc           flush and restart fetch at redirect_pc
//   ifid_valid/_instr/_instr_addr     head instruction (NOP when not valid)
//   ifid_ready                        IF/ID consumes the head
//
// Optional feature: define IF_PREFETCH_BYPASS_EN to forward a response that
// lands in the head slot straight to ifid in the same cycle.

module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_instr_addr,
    input  logic        ifid_ready
);

    localparam int          AW  = $clog2(DEPTH);
    localparam int          PW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [PW-1:0] drop_cnt, drop_nxt;
    logic [31:0]   fetch_pc;

    logic [31:0]      slot_addr  [DEPTH];
    logic [31:0]      slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;

    logic [AW-1:0] alloc_idx, fill_idx, head_idx;
    logic [PW-1:0] in_use, outstanding, drop_base, drop_redir;
    logic          full, resp_take, resp_drop, resp_seen;
    logic          bypass_hit, deq, req_acc;

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];

    // Pointers carry one extra bit so that full and empty are distinguishable.
    assign in_use      = alloc_ptr - head_ptr;
    assign outstanding = alloc_ptr - fill_ptr;
    assign full        = (in_use == PW'(DEPTH));

    // A response only counts if a request is actually owed; strays are ignored.
    assign resp_take = (state == ST_RUN)   && imem_resp_valid && (outstanding != '0);
    assign resp_drop = (state == ST_FLUSH) && imem_resp_valid && (drop_cnt != '0);
    assign resp_seen = resp_take || resp_drop;

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass_hit = resp_take && (fill_ptr == head_ptr);
`else
    assign bypass_hit = 1'b0;
`endif

    assign ifid_valid      = slot_filled[head_idx] || bypass_hit;
    assign ifid_instr      = bypass_hit            ? imem_resp_data :
                             slot_filled[head_idx] ? slot_instr[head_idx] : NOP;
    assign ifid_instr_addr = slot_addr[head_idx];
    assign deq             = ifid_valid && ifid_ready;

    // A slot freed by this cycle's dequeue may be reused by this cycle's request.
    assign imem_req_valid = (state == ST_RUN) && (!full || deq);
    assign imem_req_addr  = fetch_pc;
    assign req_acc        = imem_req_valid && imem_req_ready;

    // Responses still owed after a redirect: whatever was in flight (or already
    // pending drop), minus one arriving now, plus a request accepted now.
    assign drop_base  = (state == ST_FLUSH) ? drop_cnt : outstanding;
    assign drop_redir = drop_base - PW'(resp_seen) + PW'(req_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BOOT;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        case (state)
            ST_BOOT:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            ST_FLUSH: begin
                if (resp_drop) begin
                    drop_nxt = drop_cnt - PW'(1);
                    if (drop_cnt == PW'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default:  state_nxt = ST_BOOT;
        endcase
        if (redirect_en) begin
            drop_nxt  = drop_redir;
            state_nxt = (drop_redir != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            fetch_pc    <= RESET_PC;
            slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_addr[i]  <= '0;
                slot_instr[i] <= '0;
            end
        end else if (redirect_en) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            fetch_pc    <= redirect_pc;
            slot_filled <= '0;
        end else begin
            if (req_acc) begin
                slot_addr[alloc_idx] <= fetch_pc;
                alloc_ptr            <= alloc_ptr + PW'(1);
                fetch_pc             <= fetch_pc + 32'd4;
            end
            if (deq) begin
                slot_filled[head_idx] <= 1'b0;
                head_ptr              <= head_ptr + PW'(1);
            end
            if (resp_take) begin
                slot_instr[fill_idx] <= imem_resp_data;
                fill_ptr             <= fill_ptr + PW'(1);
                // A bypassed response consumed this cycle never occupies the slot.
                if (!(bypass_hit && deq)) begin
                    slot_filled[fill_idx] <= 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Memory must never return a word that was not requested.
    a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (resp_take || resp_drop));
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

`ifdef IF_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_instr_addr;
    logic        ifid_ready = 1'b1;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_instr_addr (ifid_instr_addr),
        .ifid_ready      (ifid_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Memory model: returns ~addr one cycle after acceptance unless stalled.
    logic [31:0] mq[$];
    logic        mem_stall = 1'b0;
    logic        pend_acc  = 1'b0;
    logic [31:0] pend_addr = '0;

    typedef struct {
        logic        ir;
        logic        rr;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ia;
    } vec_t;

    vec_t vt[30];

    function automatic vec_t mk(input logic ir, input logic rr, input logic rv,
                                input logic [31:0] ra, input logic iv, input logic [31:0] ia);
        vec_t v;
        v.ir = ir; v.rr = rr; v.rv = rv; v.ra = ra; v.iv = iv; v.ia = ia;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_cycle(input string tag, input logic rv, input logic [31:0] ra,
                               input logic iv, input logic [31:0] ia);
        check({tag, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, rv});
        check({tag, " req_addr"}, imem_req_addr, ra);
        check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, iv});
        if (iv) begin
            check({tag, " ifid_addr"}, ifid_instr_addr, ia);
            check({tag, " ifid_instr"}, ifid_instr, ~ia);
        end else begin
            check({tag, " ifid_nop"}, ifid_instr, NOP);
        end
    endtask

    // One cycle: drive inputs at the falling edge, let combinational outputs
    // settle, and note whether a request will be accepted at the next rising edge.
    task automatic step(input logic ir, input logic rr, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        if (pend_acc) mq.push_back(pend_addr);
        if (!mem_stall && mq.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mq.pop_front();
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        ifid_ready     = ir;
        imem_req_ready = rr;
        redirect_en    = redir;
        redirect_pc    = rpc;
        #1;
        pend_acc  = imem_req_valid && imem_req_ready;
        pend_addr = imem_req_addr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        check({tag, " req_addr"}, imem_req_addr, 32'h0);
        check({tag, " ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, " ifid_instr"}, ifid_instr, NOP);
        check({tag, " ifid_addr"}, ifid_instr_addr, 32'h0);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_en     = 1'b0;
        ifid_ready      = 1'b1;
        imem_req_ready  = 1'b1;
        mem_stall       = 1'b0;
        pend_acc        = 1'b0;
        mq.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Tests 1, 2, 4: startup stream, consumer stall, memory stall.
        vt[0]  = mk(1, 1, 0, 32'd0,  0, 32'd0);
        vt[1]  = mk(1, 1, 1, 32'd0,  0, 32'd0);
        vt[2]  = mk(1, 1, 1, 32'd4,  0, 32'd0);
        vt[3]  = mk(1, 1, 1, 32'd8,  1, 32'd0);
        vt[4]  = mk(1, 1, 1, 32'd12, 1, 32'd4);
        vt[5]  = mk(1, 1, 1, 32'd16, 1, 32'd8);
        vt[6]  = mk(0, 1, 1, 32'd20, 1, 32'd12);
        vt[7]  = mk(0, 1, 1, 32'd24, 1, 32'd12);
        for (int i = 8; i <= 15; i++) vt[i] = mk(0, 1, 0, 32'd28, 1, 32'd12);
        vt[16] = mk(1, 1, 1, 32'd28, 1, 32'd12);
        vt[17] = mk(1, 1, 1, 32'd32, 1, 32'd16);
        vt[18] = mk(1, 1, 1, 32'd36, 1, 32'd20);
        vt[19] = mk(1, 1, 1, 32'd40, 1, 32'd24);
        vt[20] = mk(1, 1, 1, 32'd44, 1, 32'd28);
        vt[21] = mk(1, 1, 1, 32'd48, 1, 32'd32);
        vt[22] = mk(1, 0, 1, 32'd52, 1, 32'd36);
        vt[23] = mk(1, 0, 1, 32'd52, 1, 32'd40);
        vt[24] = mk(1, 0, 1, 32'd52, 1, 32'd44);
        vt[25] = mk(1, 0, 1, 32'd52, 1, 32'd48);
        vt[26] = mk(1, 0, 1, 32'd52, 0, 32'd0);
        vt[27] = mk(1, 1, 1, 32'd52, 0, 32'd0);
        vt[28] = mk(1, 1, 1, 32'd56, 0, 32'd0);
        vt[29] = mk(1, 1, 1, 32'd60, 1, 32'd52);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(vt[i].ir, vt[i].rr, 1'b0, 32'h0);
            check_cycle($sformatf("vec%0d", i), vt[i].rv, vt[i].ra, vt[i].iv, vt[i].ia);
        end

        // Test 3: redirect with two responses in flight.
        do_reset();
        step(1, 1, 0, 32'h0);               check_cycle("t3c0", 0, 32'h0, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("t3c1", 1, 32'h0, 0, 32'h0);
        mem_stall = 1'b1;
        step(1, 1, 0, 32'h0);               check_cycle("t3c2", 1, 32'h4, 0, 32'h0);
        step(1, 0, 1, 32'h100);             check_cycle("t3c3", 1, 32'h8, 0, 32'h0);
        mem_stall = 1'b0;
        step(1, 1, 0, 32'h0);               check_cycle("t3c4 flush", 0, 32'h100, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("t3c5 flush", 0, 32'h100, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("t3c6", 1, 32'h100, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("t3c7", 1, 32'h104, 0, 32'h0);

        // Test 5: redirect together with a response, a transfer and an accept.
        step(1, 1, 1, 32'h200);             check_cycle("t5c8", 1, 32'h108, 1, 32'h100);
        step(1, 1, 0, 32'h0);               check_cycle("t5c9 flush", 0, 32'h200, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("t5c10", 1, 32'h200, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("t5c11", 1, 32'h204, 0, 32'h0);

        // Test 6: fetch address wraps through zero.
        step(1, 0, 1, 32'hFFFF_FFF8);       check_cycle("t6c12", 1, 32'h208, 1, 32'h200);
        step(1, 1, 0, 32'h0);               check_cycle("t6c13", 1, 32'hFFFF_FFF8, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        check_cycle("t6c14", 1, 32'hFFFF_FFFC, BYP, 32'hFFFF_FFF8);
        step(1, 1, 0, 32'h0);
        check_cycle("t6c15", 1, 32'h0, 1'b1, BYP ? 32'hFFFF_FFFC : 32'hFFFF_FFF8);
        step(1, 1, 0, 32'h0);
        check_cycle("t6c16", 1, 32'h4, 1'b1, BYP ? 32'h0 : 32'hFFFF_FFFC);
        step(1, 1, 0, 32'h0);
        check_cycle("t6c17", 1, 32'h8, 1'b1, BYP ? 32'h4 : 32'h0);

        // Asynchronous reset mid-operation takes effect without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        do_reset();
        step(1, 1, 0, 32'h0);               check_cycle("rr c0", 0, 32'h0, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("rr c1", 1, 32'h0, 0, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("rr c2", 1, 32'h4, BYP, 32'h0);
        step(1, 1, 0, 32'h0);               check_cycle("rr c3", 1, 32'h8, 1, BYP ? 32'h4 : 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
